stopwatch_bcd: RTL
==================

Name: stopwatch_bcd

Overview:
- Timekeeping stage directly upstream of the per-digit 7-segment decoders.
- Counts elapsed time as MM:SS.cc in BCD, under start/stop and clear push-buttons.
- Emits six 4-bit digits, one to each decoder instance driving HEX5..HEX0.
- Button inputs are raw, active-low board keys; synchronisation and edge detection happen inside this block.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (centiseconds). CLK_HZ must be an integer multiple of TICK_HZ, with CLK_HZ/TICK_HZ >= 2.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- key_start_n, in, 1, raw active-low start/stop button, asynchronous to clk.
- key_clear_n, in, 1, raw active-low clear button, asynchronous to clk.
- dig_cs0, out, 4, centiseconds ones, 0-9.
- dig_cs1, out, 4, centiseconds tens, 0-9.
- dig_s0, out, 4, seconds ones, 0-9.
- dig_s1, out, 4, seconds tens, 0-5.
- dig_m0, out, 4, minutes ones, 0-9.
- dig_m1, out, 4, minutes tens, 0-5.
- running, out, 1, high in RUN state.
- overflow, out, 1, sticky; set on wrap 59:59.99 -> 00:00.00.

Behaviour:
- Reset (reset_n low at a clk edge):
  - all digits 0, running 0, overflow 0, state IDLE;
  - prescaler 0; synchroniser flops 1; edge-detect history 1.
  - Reset wins over every other event in the same cycle, including mid-count.
- Input conditioning:
  - each key passes two flops, then a third history flop;
  - press event = (sync == 0) && (history == 1), one cycle wide.
  - Press-to-action latency is 3 clk edges after the first sampled low.
  - No debounce: the board keys are assumed clean (the team uses debounced keys).
- Prescaler:
  - counter 0..(CLK_HZ/TICK_HZ - 1), advances only in RUN;
  - tick = 1 on the cycle the counter equals its terminal value; the counter then returns to 0.
  - Held (not cleared) in PAUSE; cleared in IDLE and on clear.
- Counter chain on tick:
  - cs0 increments; on 9 it wraps to 0 and carries into cs1.
  - cs1 wraps 9 -> 0 and carries into s0.
  - s0 wraps 9 -> 0 and carries into s1.
  - s1 wraps 5 -> 0 and carries into m0.
  - m0 wraps 9 -> 0 and carries into m1.
  - m1 wraps 5 -> 0; the full wrap sets overflow.
  - All carries resolve in the same cycle; digits update on the clk edge after tick.
  - Digits never hold values outside their stated ranges.
- FSM states IDLE, RUN, PAUSE:
  - IDLE + start -> RUN.
  - RUN + start -> PAUSE.
  - PAUSE + start -> RUN, resuming from the held prescaler value.
  - clear in any state -> IDLE: digits 0, prescaler 0, overflow 0.
- Simultaneous events:
  - start and clear in the same cycle: clear wins, next state IDLE.
  - tick and clear in the same cycle: clear wins, digits 0.
  - tick and start (RUN -> PAUSE) in the same cycle: the tick is applied, then the state becomes PAUSE.
- Overflow: stays 1 while counting continues past the wrap; cleared only by clear or reset.
- running is registered: equals (state == RUN).
- Outputs are registered, with no combinational path from the keys.

Test Plan:
- CLK_HZ=10, TICK_HZ=1. Reset, press start, wait 30 clk -> running=1, cs0=3, other digits 0, overflow 0.
- From 00:00.09, next tick -> cs0=0, cs1=1. From 00:59.99, next tick -> 01:00.00.
- Press start at 00:00.05 (mid-prescale, prescaler=4), wait 50 clk, press start again -> digits hold 00:00.05 during the wait; after resume, the first increment occurs 5 clk later (prescaler continues from 4), not 10.
- Preload via run to 59:59.99, one tick -> all digits 0, overflow=1. Next tick -> cs0=1, overflow still 1. Press clear -> overflow 0, digits 0, running 0.
- Assert both keys low on the same clk -> state IDLE, digits 0, running 0.
- Pull reset_n low for one cycle while in RUN at 12:34.56 -> next edge: all digits 0, running 0. Key held low across reset release -> no press event until the key is released and pressed again.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// MM:SS.cc BCD stopwatch with start/stop and clear keys, feeding six 7-segment decoders.
// Keys are raw active-low inputs; synchronisation and press detection are done here.
module stopwatch_bcd #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] dig_cs0,
  output logic [3:0] dig_cs1,
  output logic [3:0] dig_s0,
  output logic [3:0] dig_s1,
  output logic [3:0] dig_m0,
  output logic [3:0] dig_m1,
  output logic       running,
  output logic       overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [2:0]    start_pipe, clear_pipe, fill;
  logic          start_press, clear_press, tick, wrap;
  logic [3:0]    n_cs0, n_cs1, n_s0, n_s1, n_m0, n_m1;

  // The history flop only counts once a real key sample has reached it, so a key
  // held down across reset does not produce a press until it is released first.
  assign start_press = fill[2] & ~start_pipe[1] & start_pipe[2];
  assign clear_press = fill[2] & ~clear_pipe[1] & clear_pipe[2];
  assign tick        = (state == RUN) && (presc == TERM);

  always_comb begin
    n_cs0 = dig_cs0;
    n_cs1 = dig_cs1;
    n_s0  = dig_s0;
    n_s1  = dig_s1;
    n_m0  = dig_m0;
    n_m1  = dig_m1;
    wrap  = 1'b0;
    if (clear_press) begin
      n_cs0 = 4'd0; n_cs1 = 4'd0; n_s0 = 4'd0;
      n_s1  = 4'd0; n_m0  = 4'd0; n_m1 = 4'd0;
    end else if (tick) begin
      if (dig_cs0 < 4'd9) n_cs0 = dig_cs0 + 4'd1;
      else begin
        n_cs0 = 4'd0;
        if (dig_cs1 < 4'd9) n_cs1 = dig_cs1 + 4'd1;
        else begin
          n_cs1 = 4'd0;
          if (dig_s0 < 4'd9) n_s0 = dig_s0 + 4'd1;
          else begin
            n_s0 = 4'd0;
            if (dig_s1 < 4'd5) n_s1 = dig_s1 + 4'd1;
            else begin
              n_s1 = 4'd0;
              if (dig_m0 < 4'd9) n_m0 = dig_m0 + 4'd1;
              else begin
                n_m0 = 4'd0;
                if (dig_m1 < 4'd5) n_m1 = dig_m1 + 4'd1;
                else begin
                  n_m1 = 4'd0;
                  wrap = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      presc      <= '0;
      start_pipe <= 3'b111;
      clear_pipe <= 3'b111;
      fill       <= 3'b000;
      dig_cs0    <= 4'd0;
      dig_cs1    <= 4'd0;
      dig_s0     <= 4'd0;
      dig_s1     <= 4'd0;
      dig_m0     <= 4'd0;
      dig_m1     <= 4'd0;
      running    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      start_pipe <= {start_pipe[1:0], key_start_n};
      clear_pipe <= {clear_pipe[1:0], key_clear_n};
      fill       <= {fill[1:0], 1'b1};
      dig_cs0    <= n_cs0;
      dig_cs1    <= n_cs1;
      dig_s0     <= n_s0;
      dig_s1     <= n_s1;
      dig_m0     <= n_m0;
      dig_m1     <= n_m1;
      if (clear_press) begin
        state    <= IDLE;
        presc    <= '0;
        running  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (wrap) overflow <= 1'b1;
        unique case (state)
          IDLE: begin
            presc <= '0;
            if (start_press) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (start_press) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (start_press) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
